// File: rtl/serial_rx.sv
// Start/stop framed serial receiver with a 2-FF input synchronizer and mid-bit sampling.
// Define SERIAL_RX_PARITY_EN to expect one even-parity bit between the data bits and the stop bit.
module serial_rx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              frame_err,
  output logic              parity_err,
  output logic              busy
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_W + 1);

  localparam logic [BAUD_W-1:0] BAUD_MID  = BAUD_W'(CLKS_PER_BIT / 2);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd3;
`ifdef SERIAL_RX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd4;

  logic r_par_bad;
  logic r_parity_err;
  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

  logic              r_rx_meta;
  logic              r_rx_s;
  logic [2:0]        r_state;
  logic [BAUD_W-1:0] r_baud_cnt;
  logic [BIT_W-1:0]  r_bit_cnt;
  logic [DATA_W-1:0] r_shreg;
  logic              w_sample;

  assign w_sample = (r_baud_cnt == BAUD_LAST);
  assign busy     = (r_state != S_IDLE);

  // NOTE: every flop below uses non-blocking assignment so all state updates
  // see the pre-edge values, independent of statement order in this block.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta  <= 1'b1;
      r_rx_s     <= 1'b1;
      r_state    <= S_IDLE;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shreg    <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      r_par_bad    <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_rx_meta  <= rx_in;
      r_rx_s     <= r_rx_meta;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      r_parity_err <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          r_baud_cnt <= '0;
          // The detection cycle itself counts as baud 0, so START resumes at 1.
          if (!r_rx_s) begin
            r_baud_cnt <= BAUD_W'(1);
            r_state    <= S_START;
          end
        end
        S_START: begin
          if (r_baud_cnt == BAUD_MID) begin
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_state    <= r_rx_s ? S_IDLE : S_DATA;
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (w_sample) begin
            r_baud_cnt <= '0;
            r_shreg    <= {r_rx_s, r_shreg[DATA_W-1:1]};
            r_bit_cnt  <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == BIT_LAST) begin
`ifdef SERIAL_RX_PARITY_EN
              r_state <= S_PARITY;
`else
              r_state <= S_STOP;
`endif
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end
`ifdef SERIAL_RX_PARITY_EN
        S_PARITY: begin
          if (w_sample) begin
            r_baud_cnt <= '0;
            r_par_bad  <= (r_rx_s != ^r_shreg);
            r_state    <= S_STOP;
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (w_sample) begin
            r_baud_cnt <= '0;
            r_state    <= S_IDLE;
            if (!r_rx_s) begin
              frame_err <= 1'b1;
`ifdef SERIAL_RX_PARITY_EN
            end else if (r_par_bad) begin
              r_parity_err <= 1'b1;
`endif
            end else begin
              data_out   <= r_shreg;
              data_valid <= 1'b1;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_rx.sv
// Scoreboard bench for serial_rx (CLKS_PER_BIT=4, DATA_W=8); parity frames are sent
// only when SERIAL_RX_PARITY_EN is defined.
module tb_serial_rx;

  localparam int CPB = 4;
  localparam int DW  = 8;

  localparam logic [1:0] K_VALID  = 2'd0;
  localparam logic [1:0] K_FRAME  = 2'd1;
  localparam logic [1:0] K_PARITY = 2'd2;

  typedef struct {
    logic [1:0]    kind;
    logic [DW-1:0] data;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          rx_in;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          frame_err;
  logic          parity_err;
  logic          busy;

  exp_t exp_q[$];
  int   total;
  int   bad;

  serial_rx #(.CLKS_PER_BIT(CPB), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_in      (rx_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  // Monitor: every result pulse pops one expected outcome.
  always @(negedge clk) begin
    if (data_valid || frame_err || parity_err) begin
      logic [1:0] got_kind;
      got_kind = data_valid ? K_VALID : (frame_err ? K_FRAME : K_PARITY);
      check("single_pulse", 32'(data_valid) + 32'(frame_err) + 32'(parity_err), 1);
      if (exp_q.size() == 0) begin
        check("spurious_pulse", {30'd0, got_kind}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pulse_kind", {30'd0, got_kind}, {30'd0, e.kind});
        if (e.kind == K_VALID) check("data_out", {24'd0, data_out}, {24'd0, e.data});
      end
    end
  end

  task automatic send_bit(input logic b);
    rx_in = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic idle_bits(input int n);
    repeat (n) send_bit(1'b1);
  endtask

  // Sends one frame and records the hand-computed outcome it must produce.
  task automatic send_frame(input logic [DW-1:0] d, input logic stop_bit, input logic par_bit,
                            input logic [1:0] exp_kind, input logic [DW-1:0] exp_data);
    exp_t e;
    e.kind = exp_kind;
    e.data = exp_data;
    exp_q.push_back(e);
    send_bit(1'b0);
    for (int i = 0; i < DW; i++) send_bit(d[i]);
`ifdef SERIAL_RX_PARITY_EN
    send_bit(par_bit);
`else
    if (par_bit === 1'bx) send_bit(1'b1);
`endif
    send_bit(stop_bit);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    rx_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_data_out", {24'd0, data_out}, 0);
    check("reset_busy", {31'd0, busy}, 0);
    check("reset_pulses", {29'd0, data_valid, frame_err, parity_err}, 0);
    idle_bits(2);

    // 0xA5, good stop
    send_frame(8'hA5, 1'b1, 1'b0, K_VALID, 8'hA5);
    repeat (2) @(posedge clk);
    #1;
    check("busy_after_A5", {31'd0, busy}, 0);
    idle_bits(2);

    // one-cycle glitch: START must abort at the mid-bit sample
    rx_in = 1'b0;
    @(posedge clk);
    #1;
    rx_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("glitch_busy_high", {31'd0, busy}, 1);
    @(posedge clk);
    #1;
    check("glitch_busy_low", {31'd0, busy}, 0);
    idle_bits(2);

    // 0x3C with a low stop bit
    send_frame(8'h3C, 1'b0, 1'b0, K_FRAME, 8'h00);
    idle_bits(3);
    check("hold_after_frame_err", {24'd0, data_out}, 32'hA5);

    // back-to-back frames
    send_frame(8'h00, 1'b1, 1'b0, K_VALID, 8'h00);
    send_frame(8'hFF, 1'b1, 1'b0, K_VALID, 8'hFF);
    idle_bits(2);
    check("b2b_last_word", {24'd0, data_out}, 32'hFF);

    // reset during data bit 3 of a frame
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    rx_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midreset_data_out", {24'd0, data_out}, 0);
    check("midreset_busy", {31'd0, busy}, 0);
    idle_bits(12);
    check("midreset_no_output", {24'd0, data_out}, 0);

    send_frame(8'h5A, 1'b1, 1'b0, K_VALID, 8'h5A);
    idle_bits(2);

`ifdef SERIAL_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0, K_PARITY, 8'h00);
    idle_bits(2);
    check("parity_err_hold", {24'd0, data_out}, 32'h5A);
    send_frame(8'h07, 1'b1, 1'b1, K_VALID, 8'h07);
    idle_bits(2);
`endif

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("all_outcomes_seen", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
